// File: rtl/fifo_ctrl_pkg.sv
// Shared helpers for the single-clock FIFO controller: default sizes, pointer/count
// typedefs and the wrap-around pointer increment.
package fifo_ctrl_pkg;
  localparam int DEF_FIFO_DEPTH = 64;
  localparam int DEF_ADDR_WIDTH = 6;

  typedef logic [DEF_ADDR_WIDTH-1:0] fifo_ptr_t;
  typedef logic [DEF_ADDR_WIDTH:0]   fifo_cnt_t;

  // Depth need not be a power of two, so wrap explicitly at depth-1.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_ctrl_sc_if.sv
// Requester/memory-control bundle between a FIFO requester and fifo_ctrl_sc.
interface fifo_ctrl_sc_if #(parameter int ADDR_WIDTH = 6);
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  memWrEn;
  logic [ADDR_WIDTH-1:0] memWrAddr;
  logic                  memRdEn;
  logic [ADDR_WIDTH-1:0] memRdAddr;
  logic                  rdValid;
  logic                  overflow;
  logic                  underflow;

  modport master (output push, pop, flush,
                  input  full, empty, count, memWrEn, memWrAddr, memRdEn, memRdAddr,
                         rdValid, overflow, underflow);
  modport slave  (input  push, pop, flush,
                  output full, empty, count, memWrEn, memWrAddr, memRdEn, memRdAddr,
                         rdValid, overflow, underflow);
endinterface

// File: rtl/fifo_ptr_wrap.sv
// Wrapping address counter, 0..FIFO_DEPTH-1, with synchronous clear.
module fifo_ptr_wrap
  import fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ADDR_WIDTH'(ptr_next(32'(ptr), 32'(FIFO_DEPTH)));
  end
endmodule

// File: rtl/fifo_ctrl_sc.sv
// Single-clock FIFO controller driving one dual-port memory's control pins.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_FLAGS_EN is defined.
module fifo_ctrl_sc
  import fifo_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_ctrl_sc_if.slave  bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH:0]   count, countNxt;
  logic                  full, empty, rdValid;
  logic                  pushAcc, popAcc;
  logic [ADDR_WIDTH-1:0] wrPtr, rdPtr;

  // Gating on registered full/empty is what keeps a write and a read off the same address.
  assign pushAcc = bus.push & ~full  & ~bus.flush;
  assign popAcc  = bus.pop  & ~empty & ~bus.flush;

  always_comb begin
    countNxt = count;
    case ({pushAcc, popAcc})
      2'b10:   countNxt = count + 1'b1;
      2'b01:   countNxt = count - 1'b1;
      default: countNxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rdValid <= 1'b0;
    end else if (bus.flush) begin
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rdValid <= 1'b0;
    end else begin
      count   <= countNxt;
      full    <= (countNxt == DEPTH_C);
      empty   <= (countNxt == '0);
      rdValid <= popAcc;
    end
  end

  fifo_ptr_wrap #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) uWrPtr (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush), .inc(pushAcc), .ptr(wrPtr));
  fifo_ptr_wrap #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) uRdPtr (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush), .inc(popAcc), .ptr(rdPtr));

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow, underflow;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.push & full)  overflow  <= 1'b1;
      if (bus.pop  & empty) underflow <= 1'b1;
    end
  end
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.rdValid   = rdValid;
  assign bus.memWrEn   = pushAcc;
  assign bus.memWrAddr = wrPtr;
  assign bus.memRdEn   = popAcc;
  assign bus.memRdAddr = rdPtr;
endmodule

// File: tb/tb_fifo_ctrl_sc.sv
// Two controllers (depth 4 / addr 2, depth 6 / addr 3) on shared random traffic,
// each with a behavioural memory and a queue-based reference model.
module tb_fifo_ctrl_sc;
  localparam int D0 = 4, A0 = 2, D1 = 6, A1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push = 1'b0, pop = 1'b0, flush = 1'b0;
  logic [7:0] dataIn = '0;

  always #5 clk = ~clk;

  fifo_ctrl_sc_if #(.ADDR_WIDTH(A0)) if0();
  fifo_ctrl_sc_if #(.ADDR_WIDTH(A1)) if1();
  assign if0.push = push; assign if0.pop = pop; assign if0.flush = flush;
  assign if1.push = push; assign if1.pop = pop; assign if1.flush = flush;

  fifo_ctrl_sc #(.FIFO_DEPTH(D0), .ADDR_WIDTH(A0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  fifo_ctrl_sc #(.FIFO_DEPTH(D1), .ADDR_WIDTH(A1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // dual-port memories, 1-cycle registered read
  logic [7:0] mem0 [4];
  logic [7:0] mem1 [8];
  logic [7:0] dout0, dout1;
  always @(posedge clk) begin
    if (if0.memWrEn) mem0[if0.memWrAddr] <= dataIn;
    if (if0.memRdEn) dout0 <= mem0[if0.memRdAddr];
    if (if1.memWrEn) mem1[if1.memWrAddr] <= dataIn;
    if (if1.memRdEn) dout1 <= mem1[if1.memRdAddr];
  end

  // observation arrays so checks can loop over both instances
  int   oCnt[2], oWrA[2], oRdA[2];
  logic oFull[2], oEmpty[2], oWrEn[2], oRdEn[2], oRv[2], oOv[2], oUn[2];
  logic [7:0] oDout[2];
  assign oCnt[0] = int'(if0.count);   assign oCnt[1] = int'(if1.count);
  assign oWrA[0] = int'(if0.memWrAddr); assign oWrA[1] = int'(if1.memWrAddr);
  assign oRdA[0] = int'(if0.memRdAddr); assign oRdA[1] = int'(if1.memRdAddr);
  assign oFull[0] = if0.full;   assign oFull[1] = if1.full;
  assign oEmpty[0] = if0.empty; assign oEmpty[1] = if1.empty;
  assign oWrEn[0] = if0.memWrEn; assign oWrEn[1] = if1.memWrEn;
  assign oRdEn[0] = if0.memRdEn; assign oRdEn[1] = if1.memRdEn;
  assign oRv[0] = if0.rdValid;  assign oRv[1] = if1.rdValid;
  assign oOv[0] = if0.overflow; assign oOv[1] = if1.overflow;
  assign oUn[0] = if0.underflow; assign oUn[1] = if1.underflow;
  assign oDout[0] = dout0; assign oDout[1] = dout1;

  // reference model: contents as a queue, addresses as modular indices
  int        dep[2] = '{D0, D1};
  logic [7:0] mq[2][$];
  logic [7:0] expQ[2][$];
  int        wrI[2], rdI[2];
  bit        ovf[2], unf[2], expRv[2];

  int nVec = 0, nErr = 0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s dut%0d got %0d want %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete(); expQ[k].delete();
      wrI[k] = 0; rdI[k] = 0; ovf[k] = 0; unf[k] = 0; expRv[k] = 0;
    end
  endtask

  task automatic updateModel();
    int n;
    bit pa, pp;
    for (int k = 0; k < 2; k++) begin
      n  = mq[k].size();
      pa = push && !flush && n < dep[k];
      pp = pop  && !flush && n > 0;
      if (flush) begin
        mq[k].delete();
        wrI[k] = 0; rdI[k] = 0; ovf[k] = 0; unf[k] = 0; expRv[k] = 0;
      end else begin
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        if (push && n == dep[k]) ovf[k] = 1;
        if (pop && n == 0)       unf[k] = 1;
`endif
        if (pp) begin
          expQ[k].push_back(mq[k].pop_front());
          rdI[k] = (rdI[k] + 1) % dep[k];
        end
        if (pa) begin
          mq[k].push_back(dataIn);
          wrI[k] = (wrI[k] + 1) % dep[k];
        end
        expRv[k] = pp;
      end
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    int n;
    bit ew, er;
    logic [7:0] ed;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        n  = mq[k].size();
        ew = push && !flush && n < dep[k];
        er = pop  && !flush && n > 0;
        chk("count",     k, oCnt[k], n);
        chk("full",      k, int'(oFull[k]),  int'(n == dep[k]));
        chk("empty",     k, int'(oEmpty[k]), int'(n == 0));
        chk("memWrEn",   k, int'(oWrEn[k]), int'(ew));
        chk("memWrAddr", k, oWrA[k], wrI[k]);
        chk("memRdEn",   k, int'(oRdEn[k]), int'(er));
        chk("memRdAddr", k, oRdA[k], rdI[k]);
        chk("rdValid",   k, int'(oRv[k]), int'(expRv[k]));
        chk("overflow",  k, int'(oOv[k]), int'(ovf[k]));
        chk("underflow", k, int'(oUn[k]), int'(unf[k]));
        chk("wrRdSameAddr", k, int'(oWrEn[k] && oRdEn[k] && oWrA[k] == oRdA[k]), 0);
        if (expQ[k].size() > 0) begin
          ed = expQ[k].pop_front();
          if (oRv[k]) chk("dataOut", k, int'(oDout[k]), int'(ed));
        end
      end
    end
  end

  task automatic cycle(input bit p, input bit q, input bit f);
    @(posedge clk);
    if (rst_n) updateModel();
    #1;
    push = p; pop = q; flush = f;
    dataIn = 8'($urandom);
  endtask

  task automatic randCycles(input int n, input int pPush, input int pPop);
    for (int i = 0; i < n; i++)
      cycle(($urandom % 100) < pPush, ($urandom % 100) < pPop, ($urandom % 40) == 0);
  endtask

  initial begin
    resetModel();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (8) cycle(1, 0, 0);     // fill past full
    repeat (9) cycle(0, 1, 0);     // drain past empty
    cycle(1, 1, 0);                // empty + push + pop
    repeat (6) cycle(1, 0, 0);
    repeat (3) cycle(1, 1, 0);     // full + push + pop
    cycle(0, 0, 1);
    repeat (3) cycle(1, 0, 0);
    repeat (20) cycle(1, 1, 0);    // steady state at count 3, pointers wrap
    cycle(1, 1, 1);                // flush overrides push and pop
    cycle(0, 0, 0);
    randCycles(300, 55, 45);
    randCycles(200, 45, 55);
    repeat (4) cycle(1, 0, 0);

    // asynchronous reset mid-traffic, checked between clock edges
    @(posedge clk);
    updateModel();
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rstEmpty", k, int'(oEmpty[k]), 1);
      chk("rstFull",  k, int'(oFull[k]),  0);
      chk("rstCount", k, oCnt[k], 0);
      chk("rstRdValid", k, int'(oRv[k]), 0);
    end
    push = 0; pop = 0; flush = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    randCycles(200, 50, 50);
    repeat (10) cycle(0, 1, 0);
    cycle(0, 0, 0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
